// File: rtl/branch_predict_unit.sv
// Branch resolution with a direct-mapped 2-bit BHT, misprediction redirect and
// saturating branch/misprediction performance counters.
module branch_predict_unit #(
  parameter int unsigned XLEN        = 32,
  parameter int unsigned PC_W        = 32,
  parameter int unsigned BHT_ENTRIES = 64,
  parameter int unsigned CNT_W       = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [PC_W-1:0]  if_pc,
  output logic             if_pred_taken,
  input  logic             ex_valid,
  input  logic             ex_is_branch,
  input  logic             ex_stall,
  input  logic [2:0]       ex_funct3,
  input  logic [XLEN-1:0]  ex_rs1,
  input  logic [XLEN-1:0]  ex_rs2,
  input  logic [PC_W-1:0]  ex_pc,
  input  logic [PC_W-1:0]  ex_target,
  input  logic             ex_pred_taken,
  output logic             ex_taken,
  output logic             mispredict,
  output logic [PC_W-1:0]  redirect_pc,
  output logic [CNT_W-1:0] br_count,
  output logic [CNT_W-1:0] mp_count
);

  localparam int unsigned IDX_W = $clog2(BHT_ENTRIES);

  logic [1:0]       bht_q [BHT_ENTRIES];
  logic [CNT_W-1:0] br_count_q;
  logic [CNT_W-1:0] mp_count_q;

  logic [IDX_W-1:0] if_idx;
  logic [IDX_W-1:0] ex_idx;
  logic             legal;
  logic             cond;
  logic             resolve;

  // Byte offset and high PC bits do not take part in indexing.
  logic unused_pc;
  assign unused_pc = ^{if_pc, ex_pc};

  assign if_idx        = if_pc[IDX_W+1:2];
  assign ex_idx        = ex_pc[IDX_W+1:2];
  assign if_pred_taken = bht_q[if_idx][1];

  always_comb begin
    legal = 1'b1;
    cond  = 1'b0;
    case (ex_funct3)
      3'b000:  cond = (ex_rs1 == ex_rs2);
      3'b001:  cond = (ex_rs1 != ex_rs2);
      3'b100:  cond = ($signed(ex_rs1) < $signed(ex_rs2));
      3'b101:  cond = ($signed(ex_rs1) >= $signed(ex_rs2));
      3'b110:  cond = (ex_rs1 < ex_rs2);
      3'b111:  cond = (ex_rs1 >= ex_rs2);
      default: legal = 1'b0;
    endcase
  end

  assign ex_taken    = ex_valid & ex_is_branch & legal & cond;
  assign resolve     = ex_valid & ex_is_branch & legal & ~ex_stall;
  assign mispredict  = resolve & (ex_taken != ex_pred_taken);
  assign redirect_pc = ex_taken ? ex_target : ex_pc + PC_W'(4);

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < int'(BHT_ENTRIES); i++) begin
        bht_q[i] <= 2'b01;
      end
      br_count_q <= '0;
      mp_count_q <= '0;
    end else begin
      if (resolve) begin
        if (ex_taken && bht_q[ex_idx] != 2'b11) begin
          bht_q[ex_idx] <= bht_q[ex_idx] + 2'd1;
        end else if (!ex_taken && bht_q[ex_idx] != 2'b00) begin
          bht_q[ex_idx] <= bht_q[ex_idx] - 2'd1;
        end
      end
      if (resolve && br_count_q != '1) begin
        br_count_q <= br_count_q + CNT_W'(1);
      end
      if (mispredict && mp_count_q != '1) begin
        mp_count_q <= mp_count_q + CNT_W'(1);
      end
    end
  end

  assign br_count = br_count_q;
  assign mp_count = mp_count_q;

endmodule

// File: tb/tb_branch_predict_unit.sv
// Directed plan checks plus randomized traffic against a behavioural model of
// the BHT and performance counters. Small table/counters to hit aliasing and saturation.
module tb_branch_predict_unit;

  localparam int unsigned Entries = 16;
  localparam int unsigned IdxW    = 4;
  localparam int unsigned CntW    = 8;
  localparam int          CntMax  = 255;

  logic            clk;
  logic            reset;
  logic [31:0]     if_pc;
  logic            if_pred_taken;
  logic            ex_valid;
  logic            ex_is_branch;
  logic            ex_stall;
  logic [2:0]      ex_funct3;
  logic [31:0]     ex_rs1;
  logic [31:0]     ex_rs2;
  logic [31:0]     ex_pc;
  logic [31:0]     ex_target;
  logic            ex_pred_taken;
  logic            ex_taken;
  logic            mispredict;
  logic [31:0]     redirect_pc;
  logic [CntW-1:0] br_count;
  logic [CntW-1:0] mp_count;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference state: counter values 0..3 per entry, plain integer counts.
  int mbht [Entries];
  int mbr;
  int mmp;

  branch_predict_unit #(
    .XLEN(32), .PC_W(32), .BHT_ENTRIES(Entries), .CNT_W(CntW)
  ) dut (
    .clk(clk), .reset(reset), .if_pc(if_pc), .if_pred_taken(if_pred_taken),
    .ex_valid(ex_valid), .ex_is_branch(ex_is_branch), .ex_stall(ex_stall),
    .ex_funct3(ex_funct3), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_pc(ex_pc),
    .ex_target(ex_target), .ex_pred_taken(ex_pred_taken), .ex_taken(ex_taken),
    .mispredict(mispredict), .redirect_pc(redirect_pc), .br_count(br_count),
    .mp_count(mp_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic int midx(input logic [31:0] pc);
    return int'((pc >> 2) % Entries);
  endfunction

  function automatic void model_reset();
    foreach (mbht[i]) mbht[i] = 1;
    mbr = 0;
    mmp = 0;
  endfunction

  // Branch semantics evaluated on integer values, not bit vectors.
  function automatic bit model_cond(input logic [2:0] f3, input logic [31:0] a,
                                    input logic [31:0] b);
    longint sa = longint'($signed(a));
    longint sb = longint'($signed(b));
    longint ua = longint'({32'd0, a});
    longint ub = longint'({32'd0, b});
    case (f3)
      3'd0:    return ua == ub;
      3'd1:    return ua != ub;
      3'd4:    return sa < sb;
      3'd5:    return sa >= sb;
      3'd6:    return ua < ub;
      3'd7:    return ua >= ub;
      default: return 1'b0;
    endcase
  endfunction

  // One clock: check combinational outputs, take the edge, update model, check counters.
  task automatic cycle();
    bit          legal, tk, res, mp;
    logic [31:0] rd;
    #1;
    legal = (ex_funct3 != 3'd2) && (ex_funct3 != 3'd3);
    tk    = ex_valid && ex_is_branch && legal && model_cond(ex_funct3, ex_rs1, ex_rs2);
    res   = ex_valid && ex_is_branch && legal && !ex_stall;
    mp    = res && (tk != ex_pred_taken);
    rd    = tk ? ex_target : 32'((64'(ex_pc) + 64'd4) % 64'h1_0000_0000);
    chk("if_pred_taken", if_pred_taken, mbht[midx(if_pc)] >= 2);
    chk("ex_taken", ex_taken, tk);
    chk("mispredict", mispredict, mp);
    chk("redirect_pc", redirect_pc, rd);
    @(posedge clk);
    if (reset) begin
      model_reset();
    end else if (res) begin
      if (tk) mbht[midx(ex_pc)] = (mbht[midx(ex_pc)] < 3) ? mbht[midx(ex_pc)] + 1 : 3;
      else    mbht[midx(ex_pc)] = (mbht[midx(ex_pc)] > 0) ? mbht[midx(ex_pc)] - 1 : 0;
      mbr = (mbr < CntMax) ? mbr + 1 : CntMax;
      if (mp) mmp = (mmp < CntMax) ? mmp + 1 : CntMax;
    end
    #1;
    chk("br_count", br_count, mbr);
    chk("mp_count", mp_count, mmp);
  endtask

  task automatic set_br(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] pc, input logic [31:0] tgt, input logic pred);
    ex_valid      = 1'b1;
    ex_is_branch  = 1'b1;
    ex_stall      = 1'b0;
    ex_funct3     = f3;
    ex_rs1        = a;
    ex_rs2        = b;
    ex_pc         = pc;
    ex_target     = tgt;
    ex_pred_taken = pred;
  endtask

  task automatic idle();
    ex_valid = 1'b0;
    ex_stall = 1'b0;
  endtask

  task automatic do_reset();
    idle();
    reset = 1'b1;
    cycle();
    reset = 1'b0;
  endtask

  logic [2:0] sgn_f3  [4] = '{3'd4, 3'd6, 3'd5, 3'd7};
  logic       sgn_exp [4] = '{1'b1, 1'b0, 1'b0, 1'b1};

  initial begin
    reset = 1'b1;
    if_pc = 32'h100;
    set_br(3'd0, 0, 0, 0, 0, 1'b0);
    idle();
    repeat (2) @(posedge clk);
    model_reset();
    #1;
    reset = 1'b0;

    // Reset state.
    #1;
    chk("rst_pred", if_pred_taken, 1'b0);
    chk("rst_br", br_count, 0);
    chk("rst_mp", mp_count, 0);
    cycle();

    // bne on equal operands, predicted taken.
    set_br(3'd1, 5, 5, 32'h100, 32'h180, 1'b1);
    #1;
    chk("bne_taken", ex_taken, 1'b0);
    chk("bne_mp", mispredict, 1'b1);
    chk("bne_redirect", redirect_pc, 32'h104);
    cycle();
    chk("bne_mp_count", mp_count, 1);
    // Entry now 00: one taken update leaves it not-taken.
    set_br(3'd0, 1, 1, 32'h100, 32'h140, 1'b0);
    cycle();
    idle();
    #1;
    chk("entry0_weak", if_pred_taken, 1'b0);
    cycle();

    // Three taken beq at 0x200 from a fresh table.
    do_reset();
    for (int i = 0; i < 3; i++) begin
      set_br(3'd0, 7, 7, 32'h200, 32'h240, 1'b0);
      cycle();
    end
    idle();
    if_pc = 32'h200;
    #1;
    chk("beq3_pred", if_pred_taken, 1'b1);
    chk("beq3_br", br_count, 3);
    chk("beq3_mp", mp_count, 3);
    cycle();

    // Signed versus unsigned ordering.
    for (int i = 0; i < 4; i++) begin
      set_br(sgn_f3[i], 32'hFFFF_FFFF, 32'd1, 32'h400, 32'h500, 1'b0);
      #1;
      chk($sformatf("sgn_f3_%0d", sgn_f3[i]), ex_taken, sgn_exp[i]);
      cycle();
    end

    // Illegal funct3, then a stalled taken branch.
    set_br(3'd2, 3, 3, 32'h400, 32'h500, 1'b1);
    #1;
    chk("ill_taken", ex_taken, 1'b0);
    chk("ill_mp", mispredict, 1'b0);
    cycle();
    set_br(3'd0, 9, 9, 32'h400, 32'h500, 1'b0);
    ex_stall = 1'b1;
    #1;
    chk("stall_taken", ex_taken, 1'b1);
    chk("stall_mp", mispredict, 1'b0);
    cycle();

    // PC+4 wraps at the top of the address space.
    set_br(3'd1, 2, 2, 32'hFFFF_FFFC, 32'h10, 1'b1);
    #1;
    chk("wrap_redirect", redirect_pc, 32'h0);
    cycle();

    // Same-cycle update and lookup, then reset discarding a pending update.
    do_reset();
    if_pc = 32'h300;
    set_br(3'd0, 4, 4, 32'h300, 32'h340, 1'b0);
    #1;
    chk("bypass_before", if_pred_taken, 1'b0);
    cycle();
    chk("bypass_after", if_pred_taken, 1'b1);
    reset = 1'b1;
    cycle();
    reset = 1'b0;
    idle();
    #1;
    chk("rst_pending_pred", if_pred_taken, 1'b0);
    set_br(3'd0, 4, 4, 32'h300, 32'h340, 1'b1);
    cycle();
    chk("rst_pending_01", if_pred_taken, 1'b1);

    // Randomized traffic; resets only early so the counters reach saturation later.
    for (int n = 0; n < 3000; n++) begin
      logic [31:0] a;
      a = ($urandom_range(0, 1) == 0) ? $urandom : 32'($urandom_range(0, 4)) - 32'd2;
      set_br(3'($urandom_range(0, 7)), a,
             ($urandom_range(0, 2) == 0) ? a : $urandom,
             ($urandom_range(0, 19) == 0) ? 32'hFFFF_FFFC
                                          : 32'(($urandom_range(0, 63) << 2) | $urandom_range(0, 3)),
             $urandom, 1'($urandom_range(0, 1)));
      ex_valid     = ($urandom_range(0, 7) != 0);
      ex_is_branch = ($urandom_range(0, 7) != 0);
      ex_stall     = ($urandom_range(0, 4) == 0);
      if_pc        = 32'(($urandom_range(0, 63) << 2) | $urandom_range(0, 3));
      reset        = (n < 1000) && ($urandom_range(0, 199) == 0);
      cycle();
    end
    reset = 1'b0;
    chk("sat_br", br_count, CntMax);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
